// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one cycle at accept instead.
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  input  logic [2:0]                OP,
  input  logic [DATA_WIDTH-1:0]     OPERAND1,
  input  logic [DATA_WIDTH-1:0]     OPERAND2,
  input  logic [REG_ADDR_WIDTH-1:0] RD_IN,
  input  logic                      FLUSH,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [DATA_WIDTH-1:0]     RESULT,
  output logic [REG_ADDR_WIDTH-1:0] RD_OUT
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]    MinNeg  = {1'b1, {(W - 1){1'b0}}};
  localparam logic [W-1:0]    AllOnes = '1;

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e                    state_q, state_d;
  logic [2:0]                op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [REG_ADDR_WIDTH-1:0] rd_out_q, rd_out_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      neg_q, neg_d;
  logic [W-1:0]              mcand_q, mcand_d;
  logic [2*W-1:0]            acc_q, acc_d;
  logic [W-1:0]              result_q, result_d;

  // Multiply: acc = {product high, remaining multiplier bits}, divide: acc = {remainder, quotient}.
  function automatic logic [W-1:0] sel_result(input logic [2:0] op, input logic neg,
                                               input logic [2*W-1:0] acc);
    logic [2*W-1:0] prod;
    logic [W-1:0]   part;
    logic [W-1:0]   res;
    prod = neg ? -acc : acc;
    part = op[1] ? acc[2*W-1:W] : acc[W-1:0];
    if (op[2]) begin
      res = neg ? -part : part;
    end else if (op[1:0] == 2'b00) begin
      res = prod[W-1:0];
    end else begin
      res = prod[2*W-1:W];
    end
    return res;
  endfunction

  logic         s1_en, s2_en, sign1, sign2, neg_in;
  logic [W-1:0] mag1, mag2;
  logic         div_zero, div_ovf;

  always_comb begin
    s1_en = 1'b0;
    s2_en = 1'b0;
    case (OP)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        s1_en = 1'b1;
        s2_en = 1'b1;
      end
      3'b010:  s1_en = 1'b1;
      default: ;
    endcase
    sign1    = s1_en & OPERAND1[W-1];
    sign2    = s2_en & OPERAND2[W-1];
    mag1     = sign1 ? -OPERAND1 : OPERAND1;
    mag2     = sign2 ? -OPERAND2 : OPERAND2;
    // Remainder takes the dividend's sign; everything else the product/quotient sign.
    neg_in   = (OP[2] & OP[1]) ? sign1 : (sign1 ^ sign2);
    div_zero = OP[2] && (OPERAND2 == '0);
    div_ovf  = OP[2] && !OP[0] && (OPERAND1 == MinNeg) && (OPERAND2 == AllOnes);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`endif

  logic [W-1:0]   mul_addend;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shl;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] acc_next;

  always_comb begin
    mul_addend = acc_q[0] ? mcand_q : '0;
    mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[W-1:1]};
    div_shl    = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff   = div_shl - {1'b0, mcand_q};
    if (!div_diff[W]) begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {div_shl[W-1:0], acc_q[W-2:0], 1'b0};
    end
    acc_next = op_q[2] ? div_next : mul_next;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (START && !FLUSH) begin
          op_d  = OP;
          rd_d  = RD_IN;
          neg_d = neg_in;
          cnt_d = '0;
          if (div_zero) begin
            result_d = OP[1] ? OPERAND1 : AllOnes;
            rd_out_d = RD_IN;
            state_d  = StFinish;
          end else if (div_ovf) begin
            result_d = OP[1] ? '0 : MinNeg;
            rd_out_d = RD_IN;
            state_d  = StFinish;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!OP[2]) begin
            result_d = sel_result(OP, neg_in, fast_prod);
            rd_out_d = RD_IN;
            state_d  = StFinish;
`endif
          end else begin
            mcand_d = OP[2] ? mag2 : mag1;
            acc_d   = {{W{1'b0}}, OP[2] ? mag1 : mag2};
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (FLUSH) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            result_d = sel_result(op_q, neg_q, acc_next);
            rd_out_d = rd_q;
            state_d  = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q != StIdle);
  assign DONE   = (state_q == StFinish);
  assign RESULT = result_q;
  assign RD_OUT = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: RV32M reference model, latency and control-path checks.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [2:0]  OP;
  logic [31:0] OPERAND1, OPERAND2;
  logic [4:0]  RD_IN;
  logic        BUSY, DONE;
  logic [31:0] RESULT;
  logic [4:0]  RD_OUT;

  muldiv_unit dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .OP       (OP),
    .OPERAND1 (OPERAND1),
    .OPERAND2 (OPERAND2),
    .RD_IN    (RD_IN),
    .FLUSH    (FLUSH),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT),
    .RD_OUT   (RD_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] x, y, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    x  = a;
    y  = b;
    q  = '0;
    case (op)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = x / y;
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = x % y;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int expect_lat(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op[2] && b == 0) return 0;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 0;
`endif
    return 32;
  endfunction

  // Compare every DONE pulse against the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET === 1'b0 && DONE === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'(DONE), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", RESULT, e.res);
        check_eq("rd_out", 32'(RD_OUT), 32'(e.rd));
        last_res = e.res;
        last_rd  = e.rd;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit track);
    @(negedge CLK);
    START    = 1'b1;
    OP       = op;
    OPERAND1 = a;
    OPERAND2 = b;
    RD_IN    = rd;
    if (track) sb_q.push_back('{res: exp, rd: rd});
    @(posedge CLK);
    #1;
    START    = 1'b0;
    OPERAND1 = $urandom;
    OPERAND2 = $urandom;
    RD_IN    = 5'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int busy);
    cyc  = 0;
    busy = 0;
    while (DONE !== 1'b1 && cyc < 64) begin
      if (BUSY === 1'b1) busy++;
      @(posedge CLK);
      #1;
      cyc++;
    end
    if (BUSY === 1'b1) busy++;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int cyc, busy, lat;
    lat = expect_lat(op, a, b);
    issue(op, a, b, rd, exp, 1'b1);
    wait_done(cyc, busy);
    check_eq("latency", 32'(cyc), 32'(lat));
    check_eq("busy_cycles", 32'(busy), 32'(lat + 1));
    @(posedge CLK);
    #1;
    check_eq("done_one_cycle", 32'(DONE), 32'd0);
    check_eq("idle_after_done", 32'(BUSY), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc, busy, done_before;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; OP = '0;
    OPERAND1 = '0; OPERAND2 = '0; RD_IN = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_busy", 32'(BUSY), 32'd0);
    check_eq("reset_done", 32'(DONE), 32'd0);
    check_eq("reset_result", RESULT, 32'd0);
    check_eq("reset_rd", 32'(RD_OUT), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100,       32'd7,         5'd11, 32'd14);
    run_op(3'd7, 32'd100,       32'd7,         5'd12, 32'd2);
    run_op(3'd4, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5,         32'd0,         5'd14, 32'd5);
    run_op(3'd5, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5,         32'd0,         5'd16, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0);
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 5'd19, 32'd0);
    run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd20, 32'd1);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case (i % 6)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 20);
        3: ra = -32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(rop, ra, rb, 5'(i), ref_model(rop, ra, rb));
    end

    // START while busy is dropped; only the original DIV completes.
    done_before = n_done;
    issue(3'd4, 32'hFFFF_FC18, 32'd7, 5'd21, ref_model(3'd4, 32'hFFFF_FC18, 32'd7), 1'b1);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    START = 1'b1; OP = 3'd0; OPERAND1 = 32'd3; OPERAND2 = 32'd3; RD_IN = 5'd22;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done(cyc, busy);
    check_eq("busy_start_latency", 32'(cyc), 32'd22);
    repeat (40) @(posedge CLK);
    #1;
    check_eq("busy_start_single_done", 32'(n_done - done_before), 32'd1);

    // FLUSH mid-CALC: no DONE, outputs keep the previous write-back.
    done_before = n_done;
    issue(3'd5, 32'd1000, 32'd7, 5'd23, 32'd0, 1'b0);
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    check_eq("flush_busy", 32'(BUSY), 32'd0);
    check_eq("flush_done", 32'(DONE), 32'd0);
    check_eq("flush_result", RESULT, last_res);
    check_eq("flush_rd", 32'(RD_OUT), 32'(last_rd));
    repeat (40) @(posedge CLK);
    #1;
    check_eq("flush_no_done", 32'(n_done - done_before), 32'd0);

    // Asynchronous reset between edges mid-CALC.
    issue(3'd7, 32'd12345, 32'd17, 5'd24, 32'd0, 1'b0);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_eq("async_reset_busy", 32'(BUSY), 32'd0);
    check_eq("async_reset_done", 32'(DONE), 32'd0);
    check_eq("async_reset_result", RESULT, 32'd0);
    check_eq("async_reset_rd", 32'(RD_OUT), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd25, 32'hFFFF_FFFF);

    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
